vector_shift_sequencer: RTL and testbench
=========================================

VECTOR_SHIFT_SEQUENCER -- requirements
Module: vector_shift_sequencer

Interface
REQ-001 Reset is asynchronous and active-high; one clock. Ports are listed as: name, direction, width, meaning.
REQ-002 clk_i  input  1  single clock, rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 issue_valid_i / issue_ready_o  in/out  1/1  instruction issue handshake.
REQ-005 shift_type_i  input  2  01 sll, 10 srl, 11 sra, 00 none.
REQ-006 vsew_i  input  3  element width code, forwarded unchanged to shift unit.
REQ-007 vlmul_i  input  2  group size; chunks = 1 << vlmul_i (1, 2, 4, 8).
REQ-008 vs1_addr_i, vs2_addr_i, vd_addr_i  input  5 each  base register numbers.
REQ-009 rf_rd_en_o  output  1  register-file read strobe.
REQ-010 rf_rs1_addr_o, rf_rs2_addr_o  output  5 each  read addresses.
REQ-011 rf_vs1_data_i, rf_vs2_data_i  input  128 each  read data, valid the cycle after rf_rd_en_o.
REQ-012 su_chip_enable_o  output  1  shift unit enable.
REQ-013 su_shift_type_o  output  2  shift type to shift unit.
REQ-014 su_vsew_o  output  3  element width to shift unit.
REQ-015 su_vs1_o, su_vs2_o  output  128 each  shift unit operands.
REQ-016 su_vd_i  input  128  combinational shift unit result.
REQ-017 rf_wr_en_o  output  1  write strobe.
REQ-018 rf_wr_addr_o  output  5  write address.
REQ-019 rf_wr_data_o  output  128  write data.
REQ-020 rf_wr_ready_i  input  1  write accepted when high with rf_wr_en_o.
REQ-021 busy_o  output  1  high in any state other than IDLE.
REQ-022 done_o  output  1  one-cycle completion pulse.

Function
REQ-023 States: IDLE, READ, EXEC, WRITE, DONE.
REQ-024 issue_ready_o = 1 only in IDLE.
REQ-025 Accept on issue_valid_i & issue_ready_o: latch all issue fields, chunk counter = 0, go to READ.
REQ-026 Issue inputs are ignored outside IDLE.
REQ-027 READ: rf_rd_en_o = 1 for exactly one cycle; rf_rs1_addr_o = vs1 base + chunk, rf_rs2_addr_o = vs2 base + chunk (5-bit, wraps 31->0); next state EXEC.
REQ-028 EXEC: register rf data onto su_vs1_o/su_vs2_o in the cycle it arrives; su_chip_enable_o = 1 for one cycle; next state WRITE.
REQ-029 On entering WRITE, register su_vd_i into rf_wr_data_o; rf_wr_addr_o = vd base + chunk, mod 32.
REQ-030 WRITE: hold rf_wr_en_o, rf_wr_addr_o and rf_wr_data_o stable until rf_wr_ready_i = 1.
REQ-031 On write accept: if chunk = chunks-1, go to DONE; else increment chunk and go to READ.
REQ-032 DONE: done_o = 1 for one cycle, then IDLE; the next issue can be accepted the cycle after DONE.
REQ-033 Latency with rf_wr_ready_i tied high: 3 cycles per chunk plus 1 DONE cycle (vlmul 0 -> done_o 4 cycles after accept; vlmul 3 -> 25).
REQ-034 su_chip_enable_o is 0 outside EXEC; su_shift_type_o and su_vsew_o present the latched values while busy.
REQ-035 shift_type 00 is accepted and sequenced normally; the written data is the unit result (zero).
REQ-036 At most one rf_rd_en_o and one write per chunk; no write is issued for a chunk not yet read.

Reset
REQ-037 rst_i asserted forces IDLE immediately; the chunk counter and all latched fields clear.
REQ-038 During reset all outputs are 0, except issue_ready_o, which is 1 after reset release.
REQ-039 Reset mid-operation aborts the operation with no further write and no done_o pulse.

Verification
REQ-040 vlmul 0, sll, vsew 8-bit, vs1 = 1 per byte, vs2 = 0x01 per byte, wr_ready = 1 -> one read, one write of 0x02 per byte, done_o at accept+4.
REQ-041 vlmul 2, vs2 base 30, vd base 31 -> read addresses 30, 31, 0, 1 and write addresses 31, 0, 1, 2 in order; done_o at accept+13.
REQ-042 rf_wr_ready_i held low 5 cycles in chunk 0 -> write signals stable throughout; busy_o stays high; done_o is delayed by exactly 5 cycles.
REQ-043 issue_valid_i pulsed while busy with different fields -> ignored; the operation completes with the original latched fields.
REQ-044 rst_i asserted during WRITE of chunk 1 of 4 -> rf_wr_en_o drops asynchronously; no done_o; IDLE and issue_ready_o = 1 after release.
REQ-045 sra, vsew 32-bit, element 0x80000000 with shift 4 -> written value 0xF8000000; done_o pulses exactly once.

Source files
------------

// File: rtl/vector_shift_sequencer.sv
// Vector shift sequencer: walks a register group chunk by chunk,
// reading operands, driving a combinational shift unit and writing results.
module vector_shift_sequencer (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         issue_valid_i,
   output logic         issue_ready_o,
   input  logic [1:0]   shift_type_i,
   input  logic [2:0]   vsew_i,
   input  logic [1:0]   vlmul_i,
   input  logic [4:0]   vs1_addr_i,
   input  logic [4:0]   vs2_addr_i,
   input  logic [4:0]   vd_addr_i,
   output logic         rf_rd_en_o,
   output logic [4:0]   rf_rs1_addr_o,
   output logic [4:0]   rf_rs2_addr_o,
   input  logic [127:0] rf_vs1_data_i,
   input  logic [127:0] rf_vs2_data_i,
   output logic         su_chip_enable_o,
   output logic [1:0]   su_shift_type_o,
   output logic [2:0]   su_vsew_o,
   output logic [127:0] su_vs1_o,
   output logic [127:0] su_vs2_o,
   input  logic [127:0] su_vd_i,
   output logic         rf_wr_en_o,
   output logic [4:0]   rf_wr_addr_o,
   output logic [127:0] rf_wr_data_o,
   input  logic         rf_wr_ready_i,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [2:0]   chunk_q, chunk_d;
   logic [1:0]   type_q, type_d;
   logic [2:0]   vsew_q, vsew_d;
   logic [1:0]   vlmul_q, vlmul_d;
   logic [4:0]   vs1_q, vs1_d;
   logic [4:0]   vs2_q, vs2_d;
   logic [4:0]   vd_q, vd_d;
   logic [127:0] op1_q, op1_d;
   logic [127:0] op2_q, op2_d;
   logic [127:0] wdata_q, wdata_d;
   logic [4:0]   waddr_q, waddr_d;

   logic [2:0]   chunk_last;
   logic [4:0]   chunk_ext;
   logic         busy;

   assign chunk_last = 3'((4'd1 << vlmul_q) - 4'd1);
   assign chunk_ext  = {2'b00, chunk_q};
   assign busy       = (state_q != S_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         chunk_q <= '0;
         type_q  <= '0;
         vsew_q  <= '0;
         vlmul_q <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vd_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         type_q  <= type_d;
         vsew_q  <= vsew_d;
         vlmul_q <= vlmul_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         vd_q    <= vd_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      type_d  = type_q;
      vsew_d  = vsew_q;
      vlmul_d = vlmul_q;
      vs1_d   = vs1_q;
      vs2_d   = vs2_q;
      vd_d    = vd_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue_valid_i) begin
               type_d  = shift_type_i;
               vsew_d  = vsew_i;
               vlmul_d = vlmul_i;
               vs1_d   = vs1_addr_i;
               vs2_d   = vs2_addr_i;
               vd_d    = vd_addr_i;
               chunk_d = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_EXEC;
         end
         // Operands arrive this cycle; the unit result is captured with them.
         S_EXEC: begin
            op1_d   = rf_vs1_data_i;
            op2_d   = rf_vs2_data_i;
            wdata_d = su_vd_i;
            waddr_d = vd_q + chunk_ext;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (rf_wr_ready_i) begin
               if (chunk_q == chunk_last) begin
                  state_d = S_DONE;
               end else begin
                  chunk_d = chunk_q + 3'd1;
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign issue_ready_o    = (state_q == S_IDLE) & ~rst_i;
   assign rf_rd_en_o       = (state_q == S_READ);
   assign rf_rs1_addr_o    = vs1_q + chunk_ext;
   assign rf_rs2_addr_o    = vs2_q + chunk_ext;

   // Pass fresh read data straight through while executing, hold it after.
   assign su_chip_enable_o = (state_q == S_EXEC);
   assign su_vs1_o         = (state_q == S_EXEC) ? rf_vs1_data_i : op1_q;
   assign su_vs2_o         = (state_q == S_EXEC) ? rf_vs2_data_i : op2_q;
   assign su_shift_type_o  = busy ? type_q : 2'b00;
   assign su_vsew_o        = busy ? vsew_q : 3'b000;

   assign rf_wr_en_o       = (state_q == S_WRITE);
   assign rf_wr_addr_o     = waddr_q;
   assign rf_wr_data_o     = wdata_q;

   assign busy_o           = busy;
   assign done_o           = (state_q == S_DONE);

endmodule

// File: tb/tb_vector_shift_sequencer.sv
// Bench for vector_shift_sequencer: register-file and shift-unit models
// around the DUT, checked against a chunk-by-chunk reference model.
module tb_vector_shift_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         issue_valid_i;
   logic         issue_ready_o;
   logic [1:0]   shift_type_i;
   logic [2:0]   vsew_i;
   logic [1:0]   vlmul_i;
   logic [4:0]   vs1_addr_i, vs2_addr_i, vd_addr_i;
   logic         rf_rd_en_o;
   logic [4:0]   rf_rs1_addr_o, rf_rs2_addr_o;
   logic [127:0] rf_vs1_data_i, rf_vs2_data_i;
   logic         su_chip_enable_o;
   logic [1:0]   su_shift_type_o;
   logic [2:0]   su_vsew_o;
   logic [127:0] su_vs1_o, su_vs2_o, su_vd_i;
   logic         rf_wr_en_o;
   logic [4:0]   rf_wr_addr_o;
   logic [127:0] rf_wr_data_o;
   logic         rf_wr_ready_i;
   logic         busy_o, done_o;

   vector_shift_sequencer dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .issue_valid_i    (issue_valid_i),
      .issue_ready_o    (issue_ready_o),
      .shift_type_i     (shift_type_i),
      .vsew_i           (vsew_i),
      .vlmul_i          (vlmul_i),
      .vs1_addr_i       (vs1_addr_i),
      .vs2_addr_i       (vs2_addr_i),
      .vd_addr_i        (vd_addr_i),
      .rf_rd_en_o       (rf_rd_en_o),
      .rf_rs1_addr_o    (rf_rs1_addr_o),
      .rf_rs2_addr_o    (rf_rs2_addr_o),
      .rf_vs1_data_i    (rf_vs1_data_i),
      .rf_vs2_data_i    (rf_vs2_data_i),
      .su_chip_enable_o (su_chip_enable_o),
      .su_shift_type_o  (su_shift_type_o),
      .su_vsew_o        (su_vsew_o),
      .su_vs1_o         (su_vs1_o),
      .su_vs2_o         (su_vs2_o),
      .su_vd_i          (su_vd_i),
      .rf_wr_en_o       (rf_wr_en_o),
      .rf_wr_addr_o     (rf_wr_addr_o),
      .rf_wr_data_o     (rf_wr_data_o),
      .rf_wr_ready_i    (rf_wr_ready_i),
      .busy_o           (busy_o),
      .done_o           (done_o)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Element-wise shift: vs2 elements shifted by vs1 element amounts.
   function automatic logic [127:0] shf(input logic [1:0] t,
                                        input logic [2:0] sew,
                                        input logic [127:0] a,
                                        input logic [127:0] s);
      int w, amt;
      logic [63:0] mask, e, r;
      logic [127:0] res;
      w = 8 << sew[1:0];
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      res = '0;
      for (int i = 0; i < 128 / w; i++) begin
         e = 64'(a >> (i * w)) & mask;
         amt = int'(64'(s >> (i * w)) & 64'(w - 1));
         case (t)
            2'b01: r = (e << amt) & mask;
            2'b10: r = e >> amt;
            2'b11: begin
               r = e >> amt;
               if (e[w-1]) r = r | (mask & ~(mask >> amt));
            end
            default: r = '0;
         endcase
         res = res | (128'(r) << (i * w));
      end
      return res;
   endfunction

   always_comb begin
      su_vd_i = '0;
      if (su_chip_enable_o)
         su_vd_i = shf(su_shift_type_o, su_vsew_o, su_vs2_o, su_vs1_o);
   end

   logic [127:0] mem [32];
   int cyc = 0;

   logic [4:0]   rd1_q[$], rd2_q[$], wa_q[$];
   logic [127:0] wd_q[$];
   logic [4:0]   er1[$], er2[$], ewa[$];
   logic [127:0] ewd[$];
   bit           acc_seen, rd_pend, prev_hold;
   int           acc_cyc, done_cyc, done_n, stalls;
   int           unstable, busy_bad, fld_bad;
   logic [132:0] hold_val;
   logic [127:0] nxt1, nxt2;
   logic [1:0]   exp_type;
   logic [2:0]   exp_sew;

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Observe at the falling edge, advance, then drive just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (issue_valid_i && issue_ready_o && !acc_seen) begin
         acc_seen = 1;
         acc_cyc = cyc;
      end
      rd_pend = 0;
      if (rf_rd_en_o) begin
         rd1_q.push_back(rf_rs1_addr_o);
         rd2_q.push_back(rf_rs2_addr_o);
         nxt1 = mem[rf_rs1_addr_o];
         nxt2 = mem[rf_rs2_addr_o];
         rd_pend = 1;
      end
      if (rf_wr_en_o) begin
         if (prev_hold && ({rf_wr_addr_o, rf_wr_data_o} != hold_val))
            unstable++;
         if (rf_wr_ready_i) begin
            wa_q.push_back(rf_wr_addr_o);
            wd_q.push_back(rf_wr_data_o);
            mem[rf_wr_addr_o] = rf_wr_data_o;
            prev_hold = 0;
         end else begin
            stalls++;
            prev_hold = 1;
            hold_val = {rf_wr_addr_o, rf_wr_data_o};
         end
      end else begin
         if (prev_hold && !rst) unstable++;
         prev_hold = 0;
      end
      if (done_o) begin
         done_n++;
         done_cyc = cyc;
      end
      if (acc_seen && done_n == 0 && cyc > acc_cyc && !busy_o) busy_bad++;
      if (busy_o && (su_shift_type_o != exp_type || su_vsew_o != exp_sew))
         fld_bad++;
      @(posedge clk);
      cyc++;
      #1;
      rf_vs1_data_i = rd_pend ? nxt1 : r128();
      rf_vs2_data_i = rd_pend ? nxt2 : r128();
   endtask

   task automatic clr_mon();
      rd1_q.delete(); rd2_q.delete(); wa_q.delete(); wd_q.delete();
      acc_seen = 0; prev_hold = 0;
      acc_cyc = 0; done_cyc = 0; done_n = 0; stalls = 0;
      unstable = 0; busy_bad = 0; fld_bad = 0;
   endtask

   // Reference: each chunk reads base+c, writes the shifted result to vd+c.
   task automatic model(input logic [1:0] t, input logic [2:0] sew,
                        input int n, input logic [4:0] b1,
                        input logic [4:0] b2, input logic [4:0] bd);
      logic [127:0] m [32];
      logic [4:0] a1, a2, ad;
      logic [127:0] w;
      er1.delete(); er2.delete(); ewa.delete(); ewd.delete();
      for (int i = 0; i < 32; i++) m[i] = mem[i];
      for (int c = 0; c < n; c++) begin
         a1 = 5'((int'(b1) + c) % 32);
         a2 = 5'((int'(b2) + c) % 32);
         ad = 5'((int'(bd) + c) % 32);
         w = shf(t, sew, m[a2], m[a1]);
         m[ad] = w;
         er1.push_back(a1); er2.push_back(a2);
         ewa.push_back(ad); ewd.push_back(w);
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: five stall cycles in chunk 0
   task automatic run_op(input string nm, input logic [1:0] t,
                         input logic [2:0] sew, input logic [1:0] lm,
                         input logic [4:0] b1, input logic [4:0] b2,
                         input logic [4:0] bd, input int mode,
                         input bit inject);
      int n, k, lat;
      n = 1 << lm;
      model(t, sew, n, b1, b2, bd);
      clr_mon();
      exp_type = t;
      exp_sew = sew;
      shift_type_i = t; vsew_i = sew; vlmul_i = lm;
      vs1_addr_i = b1; vs2_addr_i = b2; vd_addr_i = bd;
      issue_valid_i = 1;
      rf_wr_ready_i = (mode == 2) ? 1'b0 : 1'b1;
      k = 0;
      while (done_n == 0 && k < 400) begin
         tick();
         k++;
         if (acc_seen && inject && cyc <= acc_cyc + 2) begin
            issue_valid_i = 1;
            shift_type_i = 2'($urandom); vsew_i = 3'($urandom);
            vlmul_i = 2'($urandom);
            vs1_addr_i = 5'($urandom); vs2_addr_i = 5'($urandom);
            vd_addr_i = 5'($urandom);
         end else if (acc_seen) begin
            issue_valid_i = 0;
         end
         case (mode)
            1: rf_wr_ready_i = ($urandom % 3) != 0;
            2: rf_wr_ready_i = !(wd_q.size() == 0 && stalls < 5);
            default: rf_wr_ready_i = 1;
         endcase
      end
      if (done_n == 0) chk({nm, "_timeout"}, 128'(0), 128'(1));
      rf_wr_ready_i = 1;
      tick();
      chk({nm, "_ready_after"}, 128'(issue_ready_o), 128'(1));
      chk({nm, "_n_rd"}, 128'(rd1_q.size()), 128'(n));
      chk({nm, "_n_wr"}, 128'(wa_q.size()), 128'(n));
      for (int i = 0; i < n && i < rd1_q.size(); i++) begin
         chk({nm, "_rs1"}, 128'(rd1_q[i]), 128'(er1[i]));
         chk({nm, "_rs2"}, 128'(rd2_q[i]), 128'(er2[i]));
      end
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk({nm, "_wa"}, 128'(wa_q[i]), 128'(ewa[i]));
         chk({nm, "_wd"}, wd_q[i], ewd[i]);
      end
      lat = 3 * n + 1 + ((mode == 2) ? 5 : stalls);
      chk({nm, "_done_n"}, 128'(done_n), 128'(1));
      chk({nm, "_lat"}, 128'(done_cyc - acc_cyc), 128'(lat));
      chk({nm, "_stable"}, 128'(unstable), 128'(0));
      chk({nm, "_busy"}, 128'(busy_bad), 128'(0));
      chk({nm, "_fields"}, 128'(fld_bad), 128'(0));
   endtask

   function automatic logic any_out();
      return rf_rd_en_o | su_chip_enable_o | rf_wr_en_o | busy_o |
             done_o | issue_ready_o | (|rf_rs1_addr_o) |
             (|rf_rs2_addr_o) | (|su_shift_type_o) | (|su_vsew_o) |
             (|su_vs1_o) | (|su_vs2_o) | (|rf_wr_addr_o) |
             (|rf_wr_data_o);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int e2[4];
      int ew[4];
      logic [127:0] v;
      bit found;
      rst = 1;
      issue_valid_i = 0;
      shift_type_i = 0; vsew_i = 0; vlmul_i = 0;
      vs1_addr_i = 0; vs2_addr_i = 0; vd_addr_i = 0;
      rf_vs1_data_i = 0; rf_vs2_data_i = 0;
      rf_wr_ready_i = 1;
      exp_type = 0; exp_sew = 0;
      clr_mon();
      for (int i = 0; i < 32; i++) mem[i] = r128();
      #1;
      chk("reset_outs", 128'(any_out()), 128'(0));
      tick(); tick();
      chk("reset_hold_outs", 128'(any_out()), 128'(0));
      rst = 0;
      #1;
      chk("reset_ready", 128'(issue_ready_o), 128'(1));
      chk("reset_busy", 128'(busy_o), 128'(0));

      mem[3] = {16{8'h01}};
      mem[7] = {16{8'h01}};
      run_op("sll8", 2'b01, 3'd0, 2'd0, 5'd3, 5'd7, 5'd12, 0, 0);
      v = mem[12];
      chk("sll8_data", v, {16{8'h02}});

      run_op("wrap", 2'b10, 3'd1, 2'd2, 5'd10, 5'd30, 5'd31, 0, 0);
      e2 = '{30, 31, 0, 1};
      ew = '{31, 0, 1, 2};
      for (int i = 0; i < 4 && i < rd2_q.size(); i++)
         chk("wrap_rs2_const", 128'(rd2_q[i]), 128'(e2[i]));
      for (int i = 0; i < 4 && i < wa_q.size(); i++)
         chk("wrap_wa_const", 128'(wa_q[i]), 128'(ew[i]));

      run_op("stall", 2'b01, 3'd2, 2'd1, 5'd1, 5'd2, 5'd20, 2, 0);
      run_op("inject", 2'b11, 3'd0, 2'd1, 5'd4, 5'd8, 5'd16, 0, 1);

      mem[4] = {r128() >> 32, 32'd4};
      mem[5] = {r128() >> 32, 32'h80000000};
      run_op("sra32", 2'b11, 3'd2, 2'd0, 5'd4, 5'd5, 5'd9, 0, 0);
      v = mem[9];
      chk("sra32_data", 128'(v[31:0]), 128'(32'hF8000000));

      run_op("none", 2'b00, 3'd3, 2'd0, 5'd6, 5'd7, 5'd14, 0, 0);
      v = mem[14];
      chk("none_data", v, 128'(0));

      for (int r = 0; r < 30; r++)
         run_op("rand", 2'($urandom), 3'($urandom_range(3)), 2'($urandom),
                5'($urandom), 5'($urandom), 5'($urandom),
                int'($urandom_range(1)), bit'($urandom_range(1)));

      // Abort during the second chunk's write of a four-chunk op.
      clr_mon();
      exp_type = 2'b01; exp_sew = 3'd0;
      shift_type_i = 2'b01; vsew_i = 3'd0; vlmul_i = 2'd2;
      vs1_addr_i = 5'd0; vs2_addr_i = 5'd8; vd_addr_i = 5'd24;
      issue_valid_i = 1;
      rf_wr_ready_i = 1;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (acc_seen) issue_valid_i = 0;
         if (rf_wr_en_o && wa_q.size() == 1) found = 1;
      end
      chk("abort_reach", 128'(found), 128'(1));
      #2;
      rst = 1;
      #1;
      chk("abort_wr_en", 128'(rf_wr_en_o), 128'(0));
      chk("abort_outs", 128'(any_out()), 128'(0));
      tick(); tick();
      rst = 0;
      #1;
      chk("abort_ready", 128'(issue_ready_o), 128'(1));
      for (int k = 0; k < 10; k++) tick();
      chk("abort_no_write", 128'(wa_q.size()), 128'(1));
      chk("abort_no_done", 128'(done_n), 128'(0));
      chk("abort_idle", 128'(busy_o), 128'(0));

      run_op("post", 2'b10, 3'd0, 2'd1, 5'd2, 5'd3, 5'd4, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
